// File: rtl/deser_pkg.sv
// Shared types and constants for the serial-to-parallel byte front end.
// The bit-insertion helper keeps both shift directions in one place.
package deser_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_W - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // MSB-first pushes new bits in at [0] so the first bit ends at [7];
  // LSB-first pushes them in at [7] so the first bit ends at [0].
  function automatic logic [BYTE_W-1:0] shift_in(
    input logic [BYTE_W-1:0] cur,
    input logic              bit_in,
    input logic              msb_first
  );
    if (msb_first) begin
      return {cur[BYTE_W-2:0], bit_in};
    end
    return {bit_in, cur[BYTE_W-1:1]};
  endfunction

endpackage : deser_pkg

// File: rtl/deser_bit_cnt.sv
// Bit position counter for one serial frame: clear, count enable and a
// terminal-count flag that marks the last bit of the byte.
module deser_bit_cnt
  import deser_pkg::*;
(
  input  logic             clk,
  input  logic             areset_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear and enable together load 1: the bit taken with a frame start is bit 0.
  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q;
    if (en_i) begin
      cnt_d = cnt_d + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == CNT_LAST);

endmodule : deser_bit_cnt

// File: rtl/byte_deserializer.sv
// Collects a framed serial bit stream into a byte and offers it downstream
// over valid/ready; bytes completed while the output is still held are flagged.
module byte_deserializer
  import deser_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
)(
  input  logic              clk,
  input  logic              areset_n,
  input  logic              start,
  input  logic              sin,
  input  logic              sin_valid,
  input  logic              out_ready,
  input  logic              clr_ovr,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              busy,
  output logic              overrun
);

  // Handshake: byte_out/byte_valid form a valid/ready pair. A transfer happens
  // on any edge with byte_valid=1 and out_ready=1; while byte_valid=1 and
  // out_ready=0 the byte is held unchanged, and valid is never withdrawn
  // until it has been transferred.

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_tc;
  logic              cnt_clr;
  logic              cnt_en;

  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;

  logic              in_shift;
  logic              take_bit;
  logic              complete;
  logic              restart;
  logic [BYTE_W-1:0] shifted;
  logic              xfer;
  logic              load;
  logic              drop;

  assign in_shift = (state_q == ST_SHIFT);
  assign take_bit = sin_valid & (in_shift | start);
  // Completion outranks restart: a start on the 8th bit finishes the byte.
  assign complete = in_shift & sin_valid & cnt_tc;
  assign restart  = start & ~complete;
  assign shifted  = shift_in(restart ? '0 : shreg_q, sin, MSB_FIRST);

  assign cnt_clr  = start | complete;
  assign cnt_en   = take_bit & ~complete;

  deser_bit_cnt u_bit_cnt (
    .clk      (clk),
    .areset_n (areset_n),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .cnt_o    (cnt),
    .tc_o     (cnt_tc)
  );

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (start) begin
          state_d = ST_SHIFT;
        end else if (complete) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    xfer = valid_q & out_ready;
    load = complete & (~valid_q | out_ready);
    drop = complete & ~load;

    shreg_d = shreg_q;
    if (complete) begin
      shreg_d = '0;
    end else if (take_bit) begin
      shreg_d = shifted;
    end else if (start) begin
      shreg_d = '0;
    end

    byte_d  = byte_q;
    valid_d = valid_q;
    if (load) begin
      byte_d  = shifted;
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end

    // A new drop wins over a clear on the same edge.
    ovr_d = drop | (ovr_q & ~clr_ovr);
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      shreg_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = valid_q;
  assign busy       = in_shift;
  assign overrun    = ovr_q;

endmodule : byte_deserializer

// File: tb/tb_byte_deserializer.sv
// Directed bench for byte_deserializer: MSB-first and LSB-first instances share
// stimulus; a scoreboard queue holds bytes expected at the MSB-first output.
module tb_byte_deserializer;

  logic       clk;
  logic       areset_n;
  logic       start;
  logic       sin;
  logic       sin_valid;
  logic       out_ready;
  logic       clr_ovr;

  logic [7:0] m_byte, l_byte;
  logic       m_valid, l_valid;
  logic       m_busy, l_busy;
  logic       m_ovr, l_ovr;

  logic [7:0] exp_q[$];
  int         n_cmp;
  int         n_err;

  byte_deserializer #(.MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .areset_n   (areset_n),
    .start      (start),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .out_ready  (out_ready),
    .clr_ovr    (clr_ovr),
    .byte_out   (m_byte),
    .byte_valid (m_valid),
    .busy       (m_busy),
    .overrun    (m_ovr)
  );

  byte_deserializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .areset_n   (areset_n),
    .start      (start),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .out_ready  (out_ready),
    .clr_ovr    (clr_ovr),
    .byte_out   (l_byte),
    .byte_valid (l_valid),
    .busy       (l_busy),
    .overrun    (l_ovr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; any transfer seen at the edge is scored against the queue.
  task automatic tick();
    logic       pre_xfer;
    logic [7:0] pre_byte;
    pre_xfer = m_valid & out_ready;
    pre_byte = m_byte;
    @(posedge clk);
    #1;
    if (pre_xfer) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_xfer: observed %0h expected none", pre_byte);
      end else begin
        check("xfer_byte", {24'h0, pre_byte}, {24'h0, exp_q.pop_front()});
      end
    end
  endtask

  // driver: bits go out first-to-last as b[7] .. b[8-nbits]
  task automatic send_bits(input logic [7:0] b, input int nbits, input logic start_first,
                           input logic start_last, input logic rdy_last);
    for (int i = 0; i < nbits; i++) begin
      start     = (i == 0 && start_first) || (i == nbits - 1 && start_last);
      sin       = b[7-i];
      sin_valid = 1'b1;
      if (i == nbits - 1 && rdy_last) out_ready = 1'b1;
      tick();
    end
    start     = 1'b0;
    sin_valid = 1'b0;
    sin       = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    areset_n  = 1'b0;
    start     = 1'b0;
    sin       = 1'b0;
    sin_valid = 1'b0;
    out_ready = 1'b0;
    clr_ovr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    areset_n = 1'b1;
    tick();
    check("rst_byte", {24'h0, m_byte}, 32'h0);
    check("rst_valid", {31'h0, m_valid}, 32'h0);
    check("rst_busy", {31'h0, m_busy}, 32'h0);
    check("rst_ovr", {31'h0, m_ovr}, 32'h0);

    // 0x12 MSB-first, 0x48 LSB-first
    out_ready = 1'b1;
    exp_q.push_back(8'h12);
    send_bits(8'h12, 1, 1'b1, 1'b0, 1'b0);
    check("busy_mid_frame", {31'h0, m_busy}, 32'h1);
    send_bits(8'h24, 7, 1'b0, 1'b0, 1'b0);
    check("b12_valid", {31'h0, m_valid}, 32'h1);
    check("b12_byte", {24'h0, m_byte}, 32'h12);
    check("b12_busy", {31'h0, m_busy}, 32'h0);
    check("lsb_byte", {24'h0, l_byte}, 32'h48);
    check("lsb_valid", {31'h0, l_valid}, 32'h1);
    tick();
    check("b12_valid_one_cycle", {31'h0, m_valid}, 32'h0);

    // stalled downstream: 0xA5 held, 0x3C dropped
    out_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 8, 1'b1, 1'b0, 1'b0);
    check("a5_valid", {31'h0, m_valid}, 32'h1);
    check("a5_ovr_clear", {31'h0, m_ovr}, 32'h0);
    send_bits(8'h3C, 8, 1'b1, 1'b0, 1'b0);
    tick();
    check("hold_byte", {24'h0, m_byte}, 32'hA5);
    check("hold_valid", {31'h0, m_valid}, 32'h1);
    check("ovr_set", {31'h0, m_ovr}, 32'h1);
    out_ready = 1'b1;
    tick();
    check("a5_drained", {31'h0, m_valid}, 32'h0);
    check("ovr_sticky", {31'h0, m_ovr}, 32'h1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("ovr_cleared", {31'h0, m_ovr}, 32'h0);

    // restart after 3 bits, then 0xFF with start on bit 0
    send_bits(8'h40, 3, 1'b1, 1'b0, 1'b0);
    check("partial_busy", {31'h0, m_busy}, 32'h1);
    exp_q.push_back(8'hFF);
    send_bits(8'hFF, 8, 1'b1, 1'b0, 1'b0);
    check("ff_byte", {24'h0, m_byte}, 32'hFF);
    check("ff_valid", {31'h0, m_valid}, 32'h1);
    check("ff_no_ovr", {31'h0, m_ovr}, 32'h0);
    tick();

    // asynchronous reset mid-frame with a byte pending
    out_ready = 1'b0;
    send_bits(8'h5A, 8, 1'b1, 1'b0, 1'b0);
    send_bits(8'hC0, 5, 1'b1, 1'b0, 1'b0);
    check("pre_rst_valid", {31'h0, m_valid}, 32'h1);
    check("pre_rst_busy", {31'h0, m_busy}, 32'h1);
    areset_n = 1'b0;
    #2;
    check("async_byte", {24'h0, m_byte}, 32'h0);
    check("async_valid", {31'h0, m_valid}, 32'h0);
    check("async_busy", {31'h0, m_busy}, 32'h0);
    check("async_ovr", {31'h0, m_ovr}, 32'h0);
    check("async_lsb", {24'h0, l_byte, 8'h0} | {31'h0, l_valid}, 32'h0);
    tick();
    areset_n  = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(8'h81);
    send_bits(8'h81, 8, 1'b1, 1'b0, 1'b0);
    check("b81_byte", {24'h0, m_byte}, 32'h81);
    tick();

    // back-to-back: start on the completion edge of 0x12, then 0x34
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_bits(8'h12, 8, 1'b1, 1'b1, 1'b0);
    check("b2b_first", {24'h0, m_byte}, 32'h12);
    check("b2b_busy", {31'h0, m_busy}, 32'h1);
    send_bits(8'h34, 8, 1'b0, 1'b0, 1'b0);
    check("b2b_second", {24'h0, m_byte}, 32'h34);
    check("b2b_idle", {31'h0, m_busy}, 32'h0);
    tick();

    // ready on the completion edge: 0x11 leaves as 0x22 loads
    out_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_bits(8'h11, 8, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h22);
    send_bits(8'h22, 8, 1'b1, 1'b0, 1'b1);
    check("swap_byte", {24'h0, m_byte}, 32'h22);
    check("swap_valid", {31'h0, m_valid}, 32'h1);
    check("swap_no_ovr", {31'h0, m_ovr}, 32'h0);
    tick();
    check("swap_drained", {31'h0, m_valid}, 32'h0);
    check("queue_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_byte_deserializer
